// File: rtl/serial_eq_comparator.sv
// Bit-serial unsigned comparator: takes two WIDTH-bit operands MSB first and
// reports eq/gt/lt plus the index of the first differing bit.
module serial_eq_comparator #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [POS_W-1:0] mismatch_pos
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [POS_W-1:0] LAST_CNT = POS_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [POS_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             decided_q, decided_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic [POS_W-1:0] mpos_q, mpos_d;
  logic [POS_W-1:0] idx_c;

  assign idx_c = LAST_CNT - cnt_q;

  // Next-state, decision tracking and result load
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    decided_d = decided_q;
    dir_d     = dir_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    mpos_d    = mpos_q;

    if (start) begin
      // start wins in every state; a partial comparison is simply dropped
      state_d   = S_SHIFT;
      cnt_d     = '0;
      pos_d     = '0;
      decided_d = 1'b0;
      dir_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_SHIFT: begin
          if (bit_valid) begin
            cnt_d = cnt_q + POS_W'(1);
            if (!decided_q && (a_bit != b_bit)) begin
              decided_d = 1'b1;
              dir_d     = a_bit;
              pos_d     = idx_c;
            end
            if (cnt_q == LAST_CNT) begin
              state_d = S_DONE;
              cnt_d   = '0;
              eq_d    = ~decided_d;
              gt_d    = decided_d & dir_d;
              lt_d    = decided_d & ~dir_d;
              mpos_d  = decided_d ? pos_d : '0;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pos_q     <= '0;
      decided_q <= 1'b0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      mpos_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      decided_q <= decided_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      mpos_q    <= mpos_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign eq           = eq_q;
  assign gt           = gt_q;
  assign lt           = lt_q;
  assign mismatch_pos = mpos_q;

endmodule

// File: tb/tb_serial_eq_comparator.sv
// Bench for serial_eq_comparator: directed scenarios plus randomized
// operands/stalls, checked against an arithmetic reference model.
module tb_serial_eq_comparator;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned POS_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             bit_valid;
  logic             a_bit;
  logic             b_bit;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [POS_W-1:0] mismatch_pos;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_eq_comparator #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bit_valid    (bit_valid),
    .a_bit        (a_bit),
    .b_bit        (b_bit),
    .busy         (busy),
    .done         (done),
    .eq           (eq),
    .gt           (gt),
    .lt           (lt),
    .mismatch_pos (mismatch_pos)
  );

  // Reference: plain unsigned compare; position is the highest differing bit
  function automatic logic [5:0] ref_cmp(input logic [7:0] a, input logic [7:0] b);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 0; i < 8; i++) if (a[i] != b[i]) p = 3'(i);
    return {(a == b), (a > b), (a < b), p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one full comparison starting this cycle; reports the cycle done was
  // seen (relative to start, -1 on timeout) and the result vector at done.
  task automatic send_op(input logic [7:0] a, input logic [7:0] b,
                         input int stall_at, input int stall_n,
                         output int done_cyc, output int seq_bad,
                         output int hold_bad, output logic [5:0] res);
    logic [5:0] held;
    int cyc;
    held     = {eq, gt, lt, mismatch_pos};
    seq_bad  = 0;
    hold_bad = 0;
    done_cyc = -1;
    start     = 1'b1;
    bit_valid = 1'($urandom_range(0, 1));
    a_bit     = 1'($urandom);
    b_bit     = 1'($urandom);
    step();
    cyc   = 1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          bit_valid = 1'b0;
          a_bit     = 1'($urandom);
          b_bit     = 1'($urandom);
          if (busy !== 1'b1 || done !== 1'b0) seq_bad++;
          if ({eq, gt, lt, mismatch_pos} !== held) hold_bad++;
          step();
          cyc++;
        end
      end
      bit_valid = 1'b1;
      a_bit     = a[7-i];
      b_bit     = b[7-i];
      if (busy !== 1'b1 || done !== 1'b0) seq_bad++;
      if ({eq, gt, lt, mismatch_pos} !== held) hold_bad++;
      step();
      cyc++;
    end
    bit_valid = 1'b0;
    for (int t = 0; t < 20 && done !== 1'b1; t++) begin
      step();
      cyc++;
    end
    if (done === 1'b1) begin
      done_cyc = cyc;
      if (busy !== 1'b0) seq_bad++;
    end
    res = {eq, gt, lt, mismatch_pos};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    step(); step();
    checks++;
    if ({busy, done, eq, gt, lt, mismatch_pos} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {busy, done, eq, gt, lt, mismatch_pos});
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: busy/done got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_equal();
    int dc, sb, hb;
    logic [5:0] r;
    send_op(8'hA5, 8'hA5, 8, 0, dc, sb, hb, r);
    checks++;
    if (dc !== 9) begin errors++; $display("FAIL equal_latency: done at %0d expected 9", dc); end
    checks++;
    if (sb !== 0) begin errors++; $display("FAIL equal_busy: %0d bad busy/done cycles expected 0", sb); end
    checks++;
    if (r !== ref_cmp(8'hA5, 8'hA5)) begin
      errors++; $display("FAIL equal_result: got %b expected %b", r, ref_cmp(8'hA5, 8'hA5));
    end
    step();
    checks++;
    if ({busy, done, eq} !== 3'b001) begin
      errors++; $display("FAIL equal_after: busy/done/eq got %b expected 001", {busy, done, eq});
    end
  endtask

  task automatic test_hold();
    int dc, sb, hb;
    logic [5:0] r;
    send_op(8'h80, 8'h7F, 8, 0, dc, sb, hb, r);
    checks++;
    if (r !== ref_cmp(8'h80, 8'h7F) || dc !== 9) begin
      errors++; $display("FAIL gt_result: got %b at %0d expected %b at 9", r, dc, ref_cmp(8'h80, 8'h7F));
    end
    step(); step();
    send_op(8'h12, 8'h13, 8, 0, dc, sb, hb, r);
    checks++;
    if (hb !== 0) begin errors++; $display("FAIL hold_results: %0d changed cycles expected 0", hb); end
    checks++;
    if (r !== ref_cmp(8'h12, 8'h13) || dc !== 9) begin
      errors++; $display("FAIL lt_result: got %b at %0d expected %b at 9", r, dc, ref_cmp(8'h12, 8'h13));
    end
  endtask

  task automatic test_stall();
    int dc, sb, hb;
    logic [5:0] r;
    send_op(8'h3C, 8'h34, 2, 3, dc, sb, hb, r);
    checks++;
    if (dc !== 12) begin errors++; $display("FAIL stall_latency: done at %0d expected 12", dc); end
    checks++;
    if (r !== ref_cmp(8'h3C, 8'h34) || sb !== 0) begin
      errors++; $display("FAIL stall_result: got %b (seq_bad %0d) expected %b", r, sb, ref_cmp(8'h3C, 8'h34));
    end
  endtask

  task automatic test_abort();
    int dc, sb, hb, bad;
    logic [5:0] r, held;
    step();
    held = {eq, gt, lt, mismatch_pos};
    bad  = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
      if (busy !== 1'b1 || done !== 1'b0 || {eq, gt, lt, mismatch_pos} !== held) bad++;
      step();
    end
    send_op(8'h55, 8'h55, 8, 0, dc, sb, hb, r);
    checks++;
    if (bad !== 0 || hb !== 0) begin
      errors++; $display("FAIL abort_hold: %0d/%0d bad cycles expected 0", bad, hb);
    end
    checks++;
    if (dc !== 9 || sb !== 0) begin
      errors++; $display("FAIL abort_latency: done at %0d (seq_bad %0d) expected 9", dc, sb);
    end
    checks++;
    if (r !== ref_cmp(8'h55, 8'h55)) begin
      errors++; $display("FAIL abort_result: got %b expected %b", r, ref_cmp(8'h55, 8'h55));
    end
  endtask

  task automatic test_reset_mid();
    int dc, sb, hb;
    logic [7:0] a, b;
    logic [5:0] r;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1; a_bit = 1'($urandom); b_bit = 1'($urandom);
      step();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, eq, gt, lt, mismatch_pos} !== 8'h00) begin
      errors++; $display("FAIL reset_mid: got %b expected 00000000", {busy, done, eq, gt, lt, mismatch_pos});
    end
    bit_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    a = 8'($urandom); b = 8'($urandom);
    send_op(a, b, 8, 0, dc, sb, hb, r);
    checks++;
    if (r !== ref_cmp(a, b) || dc !== 9 || sb !== 0) begin
      errors++; $display("FAIL reset_recover: got %b at %0d expected %b at 9", r, dc, ref_cmp(a, b));
    end
  endtask

  task automatic test_back_to_back();
    int dc, sb, hb;
    logic [5:0] r;
    send_op(8'hC3, 8'h3C, 8, 0, dc, sb, hb, r);
    checks++;
    if (r !== ref_cmp(8'hC3, 8'h3C) || dc !== 9) begin
      errors++; $display("FAIL b2b_first: got %b at %0d expected %b at 9", r, dc, ref_cmp(8'hC3, 8'h3C));
    end
    send_op(8'h01, 8'h02, 8, 0, dc, sb, hb, r);
    checks++;
    if (dc !== 9 || sb !== 0) begin
      errors++; $display("FAIL b2b_latency: done at %0d (seq_bad %0d) expected 9", dc, sb);
    end
    checks++;
    if (r !== ref_cmp(8'h01, 8'h02)) begin
      errors++; $display("FAIL b2b_result: got %b expected %b", r, ref_cmp(8'h01, 8'h02));
    end
  endtask

  task automatic test_random();
    int dc, sb, hb, sa, sn, gap;
    logic [7:0] a, b;
    logic [5:0] r;
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom);
      b = (n % 4 == 0) ? a : 8'(a ^ (8'h1 << $urandom_range(0, 7)));
      if (n % 5 == 1) b = 8'($urandom);
      sa  = $urandom_range(0, 7);
      sn  = $urandom_range(0, 3);
      send_op(a, b, sa, sn, dc, sb, hb, r);
      checks++;
      if (r !== ref_cmp(a, b) || dc !== WIDTH + 1 + sn || sb !== 0 || hb !== 0) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h got %b at %0d (seq %0d hold %0d) expected %b at %0d",
                 n, a, b, r, dc, sb, hb, ref_cmp(a, b), WIDTH + 1 + sn);
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_hold();
    test_stall();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_eq_comparator.md
# serial_eq_comparator

Bit-serial magnitude/equality comparator. It receives two WIDTH-bit operands one bit per accepted cycle, MSB first, under a start/bit_valid handshake. After the last bit it reports eq/gt/lt and the position of the first differing bit. It is the serial-link counterpart to the team's parallel 2-bit equality comparator, and it sits at the receiving end of a serial operand stream.

## Interface

- WIDTH, default 8: operand width in bits; must be at least 2.
- POS_W, default $clog2(WIDTH): width of mismatch_pos; derived, not overridden.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begins a new comparison and clears the bit counter and partial result.
- bit_valid  input  1  a_bit and b_bit carry the next operand bits this cycle.
- a_bit  input  1  serial bit of operand A, MSB first.
- b_bit  input  1  serial bit of operand B, MSB first.
- busy  output  1  high while bits are being collected (SHIFT state).
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- eq  output  1  A == B.
- gt  output  1  A > B (unsigned).
- lt  output  1  A < B (unsigned).
- mismatch_pos  output  POS_W  bit index (WIDTH-1..0) of the first differing bit, MSB-first; 0 when eq.

## Operation

- States:
  - IDLE: waiting for start.
  - SHIFT: collecting WIDTH bit pairs.
  - DONE: one cycle, returns to IDLE.
- Transitions:
  - IDLE --start--> SHIFT.
  - SHIFT --WIDTH-th accepted bit--> DONE.
  - SHIFT --start--> SHIFT (restart).
  - DONE --start--> SHIFT.
  - DONE --no start--> IDLE.
- Bit acceptance:
  - A bit pair is accepted only in SHIFT with bit_valid=1.
  - bit_valid=0 in SHIFT stalls the block; the counter holds.
  - bit_valid is ignored in IDLE and DONE, and in any cycle where start=1.
- Bit counter:
  - Counts accepted bits from 0 to WIDTH-1.
  - The bit index of an accepted bit is WIDTH-1-count.
- Decision rule:
  - A sticky "decided" flag and a "dir" flag are cleared on start.
  - On the first accepted pair with a_bit != b_bit: set decided, set dir = a_bit, capture the current bit index.
  - Later pairs do not change the decision, but are still consumed until WIDTH bits have been accepted.
- Result register, loaded on entry to DONE:
  - eq = ~decided.
  - gt = decided & dir.
  - lt = decided & ~dir.
  - mismatch_pos = captured index, or 0 if not decided.
- Exactly one of eq/gt/lt is 1 after any completed comparison.
- Result outputs hold their values through IDLE and SHIFT until the next DONE.
- start during SHIFT aborts the current comparison:
  - The partial comparison is discarded and no done pulse is produced for it.
  - Previously held results are kept.

## Timing

- Reset (asynchronous assert, removal synchronous to clk):
  - state = IDLE.
  - busy = 0, done = 0, eq = 0, gt = 0, lt = 0, mismatch_pos = 0.
  - Counter and flags are cleared.
- Start latency: start sampled high at edge n puts the block in SHIFT from cycle n+1, with busy=1.
- Throughput with no stalls:
  - start at cycle 0.
  - Bits accepted in cycles 1..WIDTH.
  - done=1 and results valid in cycle WIDTH+1; busy=0 in that cycle.
  - Each stall cycle adds one cycle to completion.
- Output registration:
  - busy and done are registered state decodes.
  - Results are registered.
  - No combinational path from inputs to outputs.
- Back-to-back operation: start asserted in the DONE cycle gives SHIFT in the next cycle, with no idle gap.
- Reset mid-SHIFT:
  - All outputs return to their reset values immediately.
  - No done pulse is produced.

## Test plan

- Reset, then A=8'hA5, B=8'hA5 with no stalls, start at cycle 0 -> done at cycle 9, eq=1, gt=0, lt=0, mismatch_pos=0; busy high in cycles 1..8.
- A=8'h80, B=8'h7F -> gt=1, mismatch_pos=7. Then A=8'h12, B=8'h13 -> lt=1, mismatch_pos=0; the first result holds until the second done.
- A=8'h3C, B=8'h34 with bit_valid low for 3 cycles after the 2nd bit -> done at cycle 12, gt=1, mismatch_pos=3.
- Abort: start, 4 bits of 8'hFF/8'h00, then start again and send 8'h55/8'h55 -> a single done, 8 cycles after the second start plus one, eq=1.
- Reset mid-op: rst_n low after 5 bits -> busy/done/eq/gt/lt/mismatch_pos all 0 in the same cycle. A full new comparison after reset then completes normally.
- Back-to-back: start asserted in the DONE cycle with 8'h01 vs 8'h02 -> busy the next cycle, done 9 cycles later, lt=1, mismatch_pos=1.
